relu_pool2: RTL and testbench

RELU_POOL2 -- requirements
Module: relu_pool2

---
 rtl/conv_pkg.sv | 19 +
 rtl/pool_line_buf.sv | 29 ++
 rtl/relu_pool2.sv | 121 ++++++++++++
 tb/tb_relu_pool2.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared convolution-pipeline constants and types used by conv1 and relu_pool2.
package conv_pkg;

  // Default feature-map geometry and requantization shift
  localparam int IMG_W_DEF = 26;
  localparam int IMG_H_DEF = 26;
  localparam int SHIFT_DEF = 12;

  // Datapath widths: 32-bit accumulator in, Q-format 16-bit out
  localparam int DIN_W  = 32;
  localparam int DOUT_W = 16;

  // Largest positive value representable on the 16-bit signed output
  localparam logic [DIN_W-1:0] SAT_MAX = 32'd32767;

  typedef logic [DIN_W-1:0]  acc_t;
  typedef logic [DOUT_W-1:0] q_t;

endpackage

// File: rtl/pool_line_buf.sv
// Line buffer holding one row of horizontal pair maxima for 2x2 pooling.
// Write is registered; read is combinational so the odd row can combine in the same cycle.
module pool_line_buf
  import conv_pkg::*;
#(
  parameter int DEPTH = 13,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  acc_t          wdata,
  input  logic [AW-1:0] raddr,
  output acc_t          rdata
);

  // No reset: every entry is written on the even row before the odd row reads it
  acc_t mem_q [0:DEPTH-1];

  // Store one pair maximum per even-row pair
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/relu_pool2.sv
// ReLU followed by 2x2 max pooling on a raster-order stream, requantized to 16 bits.
// Even rows build horizontal pair maxima into a line buffer; odd rows combine them
// with the current pair and emit one pooled output per 2x2 window.
module relu_pool2
  import conv_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DIN_W-1:0]  data_in,
  input  logic              rdata_r,
  output logic [DOUT_W-1:0] data_out,
  output logic              wdata_r,
  output logic              frame_done
);

  localparam int CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LB_DEPTH = IMG_W / 2;
  localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  acc_t              pair_q, pair_d;
  logic [DOUT_W-1:0] data_out_q, data_out_d;
  logic              wdata_q, wdata_d;
  logic              frame_done_q, frame_done_d;

  acc_t          relu_val;
  acc_t          pair_max;
  acc_t          lb_rdata;
  acc_t          win_max;
  acc_t          shifted;
  q_t            sat_val;
  logic          lb_we;
  logic [AW-1:0] lb_addr;
  logic          emit;

  // ReLU, pair/window max and saturating requantize; values are non-negative after ReLU
  always_comb begin
    relu_val = data_in[DIN_W-1] ? '0 : data_in;
    pair_max = (pair_q > relu_val) ? pair_q : relu_val;
    win_max  = (lb_rdata > pair_max) ? lb_rdata : pair_max;
    shifted  = win_max >> SHIFT;
    sat_val  = (shifted > SAT_MAX) ? SAT_MAX[DOUT_W-1:0] : shifted[DOUT_W-1:0];
    lb_addr  = AW'(col_q >> 1);
    lb_we    = rdata_r && !row_q[0] && col_q[0];
    emit     = rdata_r && row_q[0] && col_q[0];
  end

  // Raster position advances only on accepted samples and wraps at frame end
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (rdata_r) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Even-column sample is held to pair with the following odd-column sample
  always_comb begin
    pair_d = pair_q;
    if (rdata_r && !col_q[0]) begin
      pair_d = relu_val;
    end
  end

  // Output register loads on each completed window and otherwise holds
  always_comb begin
    wdata_d      = emit;
    data_out_d   = emit ? sat_val : data_out_q;
    frame_done_d = emit && (row_q == ROW_LAST) && (col_q == COL_LAST);
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q        <= '0;
      row_q        <= '0;
      pair_q       <= '0;
      data_out_q   <= '0;
      wdata_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      pair_q       <= pair_d;
      data_out_q   <= data_out_d;
      wdata_q      <= wdata_d;
      frame_done_q <= frame_done_d;
    end
  end

  pool_line_buf #(
    .DEPTH (LB_DEPTH),
    .AW    (AW)
  ) u_line_buf (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (pair_max),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

  assign data_out   = data_out_q;
  assign wdata_r    = wdata_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_relu_pool2.sv
// Self-checking bench for relu_pool2: directed frames against a pooled-map model.
module tb_relu_pool2;

  localparam int W    = 26;
  localparam int H    = 26;
  localparam int SH   = 12;
  localparam int NOUT = (W / 2) * (H / 2);

  localparam int K_RAMP = 0;
  localparam int K_NEG  = 1;
  localparam int K_SAT  = 2;

  localparam int M_NONE = 0;
  localparam int M_RAMP = 1;
  localparam int M_NEG  = 2;
  localparam int M_SAT  = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] data_in;
  logic        rdata_r;
  logic [15:0] data_out;
  logic        wdata_r;
  logic        frame_done;

  relu_pool2 dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_in    (data_in),
    .rdata_r    (rdata_r),
    .data_out   (data_out),
    .wdata_r    (wdata_r),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Model state: current frame image and expectations for the next sampling point
  int          frame_img [H][W];
  int          pos;
  logic        exp_valid;
  logic        exp_fd;
  logic [15:0] exp_data;
  int          exp_idx;
  int          exp_mode;
  int          mode;

  int compare_count = 0;
  int fail_count    = 0;

  function automatic longint relu(input int v);
    return (v < 0) ? 64'sd0 : longint'(v);
  endfunction

  // Pooled output for window (pr, pc): max of four ReLU values, shift, clamp
  function automatic logic [15:0] pool_expect(input int pr, input int pc);
    longint m = 0;
    for (int dr = 0; dr < 2; dr++) begin
      for (int dc = 0; dc < 2; dc++) begin
        if (relu(frame_img[2*pr+dr][2*pc+dc]) > m) m = relu(frame_img[2*pr+dr][2*pc+dc]);
      end
    end
    m = m >>> SH;
    if (m > 32767) m = 32767;
    return 16'(m);
  endfunction

  function automatic int sample_value(input int kind, input int r, input int c);
    int v;
    case (kind)
      K_NEG:   v = -5000;
      K_SAT:   v = (r == 10 && c == 10) ? 32'h7FFF_FFFF : ((r * W + c) << SH);
      default: v = (r * W + c) << SH;
    endcase
    return v;
  endfunction

  // Drive one cycle, then update what the outputs must show after that edge
  task automatic applyStimulus(input int value, input bit valid);
    int r;
    int c;
    data_in = value;
    rdata_r = valid;
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    exp_fd    = 1'b0;
    if (valid) begin
      r = pos / W;
      c = pos % W;
      frame_img[r][c] = value;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        exp_valid = 1'b1;
        exp_idx   = (r / 2) * (W / 2) + c / 2;
        exp_data  = pool_expect(r / 2, c / 2);
        exp_fd    = (exp_idx == NOUT - 1);
        exp_mode  = mode;
      end
      pos = (pos + 1) % (W * H);
    end
  endtask

  task automatic runFrame(input int kind, input bit gaps);
    for (int i = 0; i < W * H; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        repeat ($urandom_range(1, 3)) applyStimulus(int'($urandom), 1'b0);
      end
      applyStimulus(sample_value(kind, i / W, i % W), 1'b1);
    end
  endtask

  // One-cycle reset with a valid sample present that must be ignored
  task automatic doReset();
    reset_n   = 1'b0;
    rdata_r   = 1'b1;
    data_in   = 32'h0001_0000;
    exp_valid = 1'b0;
    exp_fd    = 1'b0;
    exp_data  = '0;
    pos       = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    compare_count++;
    if (actual != expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    checkOutput("wdata_r", longint'(wdata_r), longint'(exp_valid));
    checkOutput("data_out", longint'(data_out), longint'(exp_data));
    checkOutput("frame_done", longint'(frame_done), longint'(exp_fd));
    if (exp_valid) begin
      case (exp_mode)
        M_RAMP: begin
          if (exp_idx == 0) checkOutput("ramp_first", longint'(data_out), 27);
          else if (exp_idx == NOUT - 1) checkOutput("ramp_last", longint'(data_out), 675);
        end
        M_NEG: checkOutput("neg_zero", longint'(data_out), 0);
        M_SAT: begin
          if (exp_idx == 5 * (W / 2) + 5) checkOutput("sat_window", longint'(data_out), 32767);
        end
        default: ;
      endcase
    end
  end

  initial begin
    reset_n   = 1'b0;
    rdata_r   = 1'b0;
    data_in   = '0;
    exp_valid = 1'b0;
    exp_fd    = 1'b0;
    exp_data  = '0;
    exp_idx   = 0;
    exp_mode  = M_NONE;
    mode      = M_NONE;
    pos       = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    $display("[TB] ramp frame, continuous");
    mode = M_RAMP;
    runFrame(K_RAMP, 1'b0);

    $display("[TB] all-negative frame");
    mode = M_NEG;
    runFrame(K_NEG, 1'b0);

    $display("[TB] saturation frame");
    mode = M_SAT;
    runFrame(K_SAT, 1'b0);

    $display("[TB] ramp frame with random gaps");
    mode = M_RAMP;
    runFrame(K_RAMP, 1'b1);

    $display("[TB] reset at sample 300, then full ramp frame");
    for (int i = 0; i < 300; i++) applyStimulus(sample_value(K_RAMP, i / W, i % W), 1'b1);
    doReset();
    runFrame(K_RAMP, 1'b0);

    $display("[TB] two back-to-back ramp frames");
    runFrame(K_RAMP, 1'b0);
    runFrame(K_RAMP, 1'b0);

    repeat (3) applyStimulus(0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", compare_count, fail_count);
    $finish;
  end

endmodule
